// File: rtl/n25q_pkg.sv
// Shared types and constants for the N25Q command sequencer.
// States, opcodes and the filler byte used for dummy/read phases.
package n25q_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPC,
    ADDR,
    DUMMY,
    WRITE,
    READ,
    DESEL
  } state_t;

  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_PP        = 8'h02;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_SE        = 8'hD8;

  localparam logic [7:0] DUMMY_BYTE   = 8'h00;

endpackage

// File: rtl/n25q_byte_issuer.sv
// Single-outstanding go/done byte handshake toward spi_master.
// Holds the issued byte on byte_tx until its done pulse returns.
module n25q_byte_issuer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] tx_in,
  input  logic       byte_done,
  output logic       byte_go,
  output logic [7:0] byte_tx,
  output logic       done
);

  logic       pend;
  logic [7:0] tx_q;

  assign byte_go = req & ~pend;
  assign byte_tx = pend ? tx_q : tx_in;
  assign done    = byte_done & pend;

  // Track the one byte in flight; stray done pulses are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      tx_q <= 8'h00;
    end else if (byte_go) begin
      pend <= 1'b1;
      tx_q <= tx_in;
    end else if (done) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/n25q_cmd_seq.sv
// N25Q command sequencer: splits one command descriptor into
// byte transactions and owns chip select for the whole command.
module n25q_cmd_seq
  import n25q_pkg::*;
#(
  parameter int ADDR_BYTES = 3,
  parameter int LEN_W      = 9,
  parameter int CS_SETUP   = 2,
  parameter int CS_DESEL   = 4
) (
  input  logic                    ifclk,
  input  logic                    resetb,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_opcode,
  input  logic                    cmd_has_addr,
  input  logic [8*ADDR_BYTES-1:0] cmd_addr,
  input  logic [3:0]              cmd_dummy,
  input  logic [LEN_W-1:0]        cmd_wr_len,
  input  logic [LEN_W-1:0]        cmd_rd_len,
  input  logic [7:0]              wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    busy,
  output logic                    cmd_done,
  output logic                    byte_go,
  output logic [7:0]              byte_tx,
  input  logic [7:0]              byte_rx,
  input  logic                    byte_done,
  output logic                    csb
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [7:0]       opc_q;
  logic             has_addr_q;
  logic [AW-1:0]    addr_q;
  logic [3:0]       dummy_q;
  logic [LEN_W-1:0] wr_len_q;
  logic [LEN_W-1:0] rd_len_q;
  logic             live;
  logic             csb_q;
  logic             rd_valid_q;
  logic [7:0]       rd_data_q;
  logic             req;
  logic             done;
  logic             accept;
  logic             last;
  logic [7:0]       tx_sel;

  assign cmd_ready = live & (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);
  assign csb       = csb_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wr_ready  = (state == WRITE) & byte_go;
  assign last      = (cnt == ONE);

  n25q_byte_issuer u_issuer (
    .clk       (ifclk),
    .rst_n     (resetb),
    .req       (req),
    .tx_in     (tx_sel),
    .byte_done (byte_done),
    .byte_go   (byte_go),
    .byte_tx   (byte_tx),
    .done      (done)
  );

  // State and phase counter register.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Phase sequencing; later checks override to pick the first non-empty phase.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    req      = 1'b0;
    tx_sel   = DUMMY_BYTE;
    cmd_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SETUP;
          cnt_n   = LEN_W'(CS_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) state_n = OPC;
        else cnt_n = cnt - ONE;
      end
      OPC: begin
        req    = 1'b1;
        tx_sel = opc_q;
      end
      ADDR: begin
        req    = 1'b1;
        tx_sel = addr_q[AW-1 -: 8];
      end
      DUMMY: req = 1'b1;
      WRITE: begin
        req    = wr_valid;
        tx_sel = wr_data;
      end
      READ: req = ~rd_valid_q;
      DESEL: begin
        if (cnt == '0) begin
          state_n  = IDLE;
          cmd_done = 1'b1;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (done) begin
      if (state != OPC && !last) begin
        cnt_n = cnt - ONE;
      end else begin
        state_n = DESEL;
        cnt_n   = LEN_W'(CS_DESEL - 1);
        if (state != READ && rd_len_q != '0) begin
          state_n = READ;
          cnt_n   = rd_len_q;
        end
        if (state inside {OPC, ADDR, DUMMY} && wr_len_q != '0) begin
          state_n = WRITE;
          cnt_n   = wr_len_q;
        end
        if (state inside {OPC, ADDR} && dummy_q != '0) begin
          state_n = DUMMY;
          cnt_n   = LEN_W'(dummy_q);
        end
        if (state == OPC && has_addr_q) begin
          state_n = ADDR;
          cnt_n   = LEN_W'(ADDR_BYTES);
        end
      end
    end
  end

  // Latch the descriptor; shift the address so the MSB byte is on top.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      opc_q      <= 8'h00;
      has_addr_q <= 1'b0;
      addr_q     <= '0;
      dummy_q    <= 4'h0;
      wr_len_q   <= '0;
      rd_len_q   <= '0;
    end else if (accept) begin
      opc_q      <= cmd_opcode;
      has_addr_q <= cmd_has_addr;
      addr_q     <= cmd_addr;
      dummy_q    <= cmd_dummy;
      wr_len_q   <= cmd_wr_len;
      rd_len_q   <= cmd_rd_len;
    end else if (done && state == ADDR) begin
      addr_q <= addr_q << 8;
    end
  end

  // Chip select low from the cycle after accept until deselect.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      csb_q <= 1'b1;
      live  <= 1'b0;
    end else begin
      csb_q <= (state_n == IDLE) || (state_n == DESEL);
      live  <= 1'b1;
    end
  end

  // Read payload holding register; next read byte waits for its accept.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else if (done && state == READ) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= byte_rx;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_n25q_cmd_seq.sv
// Directed bench for n25q_cmd_seq with an spi_master byte model
// and tx/rd scoreboards.
`timescale 1ns/1ps
module tb_n25q_cmd_seq;
  import n25q_pkg::*;

  localparam int ADDR_BYTES = 3;
  localparam int LEN_W      = 9;
  localparam int CS_SETUP   = 2;
  localparam int CS_DESEL   = 4;
  localparam int LAT        = 3;

  logic        ifclk = 1'b0;
  logic        resetb = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode = 8'h00;
  logic        cmd_has_addr = 1'b0;
  logic [23:0] cmd_addr = 24'h0;
  logic [3:0]  cmd_dummy = 4'h0;
  logic [8:0]  cmd_wr_len = 9'h0;
  logic [8:0]  cmd_rd_len = 9'h0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy;
  logic        cmd_done;
  logic        byte_go;
  logic [7:0]  byte_tx;
  logic [7:0]  byte_rx = 8'h00;
  logic        byte_done = 1'b0;
  logic        csb;

  always #5 ifclk = ~ifclk;

  n25q_cmd_seq #(
    .ADDR_BYTES (ADDR_BYTES),
    .LEN_W      (LEN_W),
    .CS_SETUP   (CS_SETUP),
    .CS_DESEL   (CS_DESEL)
  ) dut (
    .ifclk        (ifclk),
    .resetb       (resetb),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_has_addr (cmd_has_addr),
    .cmd_addr     (cmd_addr),
    .cmd_dummy    (cmd_dummy),
    .cmd_wr_len   (cmd_wr_len),
    .cmd_rd_len   (cmd_rd_len),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .cmd_done     (cmd_done),
    .byte_go      (byte_go),
    .byte_tx      (byte_tx),
    .byte_rx      (byte_rx),
    .byte_done    (byte_done),
    .csb          (csb)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] obs_tx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] obs_rd[$];
  logic [7:0] rx_q[$];
  logic [7:0] wr_src[$];

  int cd = 0;
  int go_cnt = 0;
  int viol = 0;
  int done_pulses = 0;
  int wr_acc = 0;
  int low_run = 0;
  int hi_run = 0;
  int last_low = 0;
  int gos_in_run = 0;
  int first_go_at = 0;
  int desel_at_done = 0;
  int csb_rises = 0;
  logic [7:0] rx_hold = 8'h00;
  logic [7:0] tx_hold = 8'h00;

  // spi_master byte model and protocol monitor, sampled mid-cycle.
  always @(negedge ifclk) begin
    if (!resetb) begin
      cd        <= 0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (cd == 1) begin
        byte_done <= 1'b1;
        byte_rx   <= rx_hold;
      end
      if (cd != 0) cd <= cd - 1;
      if ((byte_go && cd != 0) || (byte_go && csb) ||
          (byte_go && rd_valid) || (wr_ready && !byte_go) ||
          (wr_ready && byte_tx !== wr_data) ||
          (cd != 0 && byte_tx !== tx_hold) ||
          (cd != 0 && csb) || (cmd_done && !csb))
        viol <= viol + 1;
      if (byte_go) begin
        obs_tx.push_back(byte_tx);
        go_cnt  <= go_cnt + 1;
        cd      <= LAT;
        tx_hold <= byte_tx;
        rx_hold <= (rx_q.size() != 0) ? rx_q.pop_front() : 8'hEE;
        if (gos_in_run == 0) first_go_at <= low_run;
        gos_in_run <= gos_in_run + 1;
      end
      if (csb) begin
        hi_run <= hi_run + 1;
        if (low_run != 0) begin
          last_low  <= low_run;
          csb_rises <= csb_rises + 1;
        end
        low_run    <= 0;
        gos_in_run <= 0;
      end else begin
        low_run <= low_run + 1;
        hi_run  <= 0;
      end
      if (cmd_done) begin
        done_pulses   <= done_pulses + 1;
        desel_at_done <= hi_run + 1;
      end
      if (rd_valid && rd_ready) obs_rd.push_back(rd_data);
      if (wr_valid && wr_ready) wr_acc <= wr_acc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    logic [7:0] o;
    while (obs_tx.size() != 0) begin
      o = obs_tx.pop_front();
      if (exp_tx.size() != 0) chk("tx_byte", 32'(o), 32'(exp_tx.pop_front()));
      else chk("tx_extra", 32'(o), 32'h100);
    end
    while (obs_rd.size() != 0) begin
      o = obs_rd.pop_front();
      if (exp_rd.size() != 0) chk("rd_byte", 32'(o), 32'(exp_rd.pop_front()));
      else chk("rd_extra", 32'(o), 32'h100);
    end
  endtask

  task automatic tick();
    @(posedge ifclk);
    #1;
    drain();
  endtask

  int v0, r0, g0;

  task automatic issue(input string tag, input logic [7:0] opc,
                       input logic ha, input logic [23:0] addr,
                       input logic [3:0] dm, input logic [8:0] wl,
                       input logic [8:0] rl);
    int n;
    n = 0;
    v0 = viol;
    r0 = csb_rises;
    g0 = go_cnt;
    cmd_opcode   = opc;
    cmd_has_addr = ha;
    cmd_addr     = addr;
    cmd_dummy    = dm;
    cmd_wr_len   = wl;
    cmd_rd_len   = rl;
    cmd_valid    = 1'b1;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_csb_low"}, csb, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic finish_cmd(input string tag, input int rd_hold,
                            input int wr_gap);
    int n, base, gap, hold, acc;
    bit seen;
    n = 0;
    base = done_pulses;
    gap = wr_gap;
    hold = 0;
    acc = wr_acc;
    seen = 1'b0;
    while (done_pulses == base && n < 3000) begin
      if (wr_acc != acc) begin
        acc = wr_acc;
        void'(wr_src.pop_front());
        gap = wr_gap;
      end
      if (gap > 0) begin
        gap--;
        wr_valid = 1'b0;
      end else begin
        wr_valid = (wr_src.size() != 0);
        wr_data  = wr_valid ? wr_src[0] : 8'h00;
      end
      if (rd_valid && !seen) begin
        seen = 1'b1;
        hold = rd_hold;
      end
      if (hold > 0) begin
        hold--;
        rd_ready = 1'b0;
      end else begin
        rd_ready = 1'b1;
      end
      tick();
      n++;
    end
    chk({tag, "_finished"}, n < 3000, 1);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (2) tick();
    chk({tag, "_tx_left"}, exp_tx.size(), 0);
    chk({tag, "_rd_left"}, exp_rd.size(), 0);
    chk({tag, "_protocol"}, viol - v0, 0);
    chk({tag, "_cs_once"}, csb_rises - r0, 1);
    chk({tag, "_setup"}, first_go_at, CS_SETUP);
    chk({tag, "_desel"}, desel_at_done, CS_DESEL);
    chk({tag, "_idle"}, {busy, cmd_ready, csb}, 3'b011);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge ifclk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_csb", csb, 1);
    chk("rst_busy", busy, 0);
    chk("rst_byte_go", byte_go, 0);
    chk("rst_byte_tx", byte_tx, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cmd_done", cmd_done, 0);
    resetb = 1'b1;
    tick();
    chk("idle_ready", cmd_ready, 1);
    chk("idle_csb", csb, 1);

    exp_tx.push_back(OP_WREN);
    rx_q.push_back(8'hFF);
    issue("wren", OP_WREN, 1'b0, 24'h0, 4'h0, 9'd0, 9'd0);
    finish_cmd("wren", 0, 0);
    chk("wren_gos", go_cnt - g0, 1);
    chk("wren_cs_low", last_low, CS_SETUP + 1 + LAT);

    exp_tx = '{OP_RDID, 8'h00, 8'h00, 8'h00};
    rx_q   = '{8'hFF, 8'h20, 8'hBA, 8'h18};
    exp_rd = '{8'h20, 8'hBA, 8'h18};
    issue("rdid", OP_RDID, 1'b0, 24'h0, 4'h0, 9'd0, 9'd3);
    finish_cmd("rdid", 0, 0);

    exp_tx = '{OP_READ, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
    rx_q   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    exp_rd = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    issue("read", OP_READ, 1'b1, 24'h012345, 4'h0, 9'd0, 9'd4);
    finish_cmd("read", 10, 0);
    chk("read_gos", go_cnt - g0, 8);

    exp_tx = '{OP_FAST_READ, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    rx_q   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA1, 8'hB2};
    exp_rd = '{8'hA1, 8'hB2};
    issue("fast", OP_FAST_READ, 1'b1, 24'h000100, 4'h1, 9'd0, 9'd2);
    finish_cmd("fast", 0, 0);

    exp_tx = '{OP_PP, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55};
    wr_src = '{8'hAA, 8'h55};
    issue("pp", OP_PP, 1'b1, 24'h000000, 4'h0, 9'd2, 9'd0);
    finish_cmd("pp", 0, 5);
    chk("pp_wr_acc", wr_src.size(), 0);

    exp_tx = '{OP_READ, 8'h12, 8'h34, 8'h56};
    issue("abort", OP_READ, 1'b1, 24'h123456, 4'h0, 9'd0, 9'd2);
    n = 0;
    while (go_cnt - g0 < 2 && n < 200) begin
      tick();
      n++;
    end
    chk("abort_in_addr", go_cnt - g0, 2);
    resetb = 1'b0;
    #1;
    chk("abort_csb", csb, 1);
    chk("abort_byte_go", byte_go, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 0);
    exp_tx.delete();
    rx_q.delete();
    repeat (2) tick();
    resetb = 1'b1;
    tick();
    chk("abort_idle_ready", cmd_ready, 1);

    exp_tx = '{OP_RDID, 8'h00, 8'h00, 8'h00};
    rx_q   = '{8'hFF, 8'h20, 8'hBA, 8'h18};
    exp_rd = '{8'h20, 8'hBA, 8'h18};
    issue("rdid2", OP_RDID, 1'b0, 24'h0, 4'h0, 9'd0, 9'd3);
    finish_cmd("rdid2", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
